// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Opcodes, FSM states, lane masks and lane helpers for the
//               MEM-stage data RAM front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_OP_LB  = 4'h1;
    localparam logic [3:0] MEM_OP_LBU = 4'h2;
    localparam logic [3:0] MEM_OP_LH  = 4'h3;
    localparam logic [3:0] MEM_OP_LHU = 4'h4;
    localparam logic [3:0] MEM_OP_LW  = 4'h5;
    localparam logic [3:0] MEM_OP_SB  = 4'h6;
    localparam logic [3:0] MEM_OP_SH  = 4'h7;
    localparam logic [3:0] MEM_OP_SW  = 4'h8;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_RESP   = 2'd2
    } mau_state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_t;

    // Big-endian: the lowest byte address lives in bits 31:24.
    localparam logic [3:0] LANE_B0 = 4'b1000;
    localparam logic [3:0] LANE_B1 = 4'b0100;
    localparam logic [3:0] LANE_B2 = 4'b0010;
    localparam logic [3:0] LANE_B3 = 4'b0001;
    localparam logic [3:0] LANE_H0 = 4'b1100;
    localparam logic [3:0] LANE_H1 = 4'b0011;
    localparam logic [3:0] LANE_W  = 4'b1111;

    function automatic mem_size_t op_size(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: op_size = SZ_BYTE;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: op_size = SZ_HALF;
            MEM_OP_LW, MEM_OP_SW:             op_size = SZ_WORD;
            default:                          op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = (op_size(op) != SZ_NONE) && !op_is_store(op);
    endfunction

    function automatic logic misaligned(input mem_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: misaligned = lo[0];
            SZ_WORD: misaligned = (lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input mem_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: begin
                case (lo)
                    2'b00:   lane_mask = LANE_B0;
                    2'b01:   lane_mask = LANE_B1;
                    2'b10:   lane_mask = LANE_B2;
                    default: lane_mask = LANE_B3;
                endcase
            end
            SZ_HALF: lane_mask = lo[1] ? LANE_H1 : LANE_H0;
            SZ_WORD: lane_mask = LANE_W;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input mem_size_t sz, input logic [31:0] wdata);
        case (sz)
            SZ_BYTE: store_data = {4{wdata[7:0]}};
            SZ_HALF: store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational lane extract and sign/zero extend of a RAM word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = 8'h00;
        w_half   = addr_lo_i[1] ? word_i[15:0] : word_i[31:16];
        result_o = 32'h0000_0000;
        case (addr_lo_i)
            2'b00:   w_byte = word_i[31:24];
            2'b01:   w_byte = word_i[23:16];
            2'b10:   w_byte = word_i[15:8];
            default: w_byte = word_i[7:0];
        endcase
        case (op_i)
            MEM_OP_LB:  result_o = {{24{w_byte[7]}}, w_byte};
            MEM_OP_LBU: result_o = {24'h00_0000, w_byte};
            MEM_OP_LH:  result_o = {{16{w_half[15]}}, w_half};
            MEM_OP_LHU: result_o = {16'h0000, w_half};
            MEM_OP_LW:  result_o = word_i;
            default:    result_o = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store sequencer for the byte-lane RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              exc_adel_o,
    output logic              exc_ades_o,
    output logic              stall_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    mau_state_t r_state;
    logic [3:0] r_op;
    logic [1:0] r_addr_lo;

    mem_size_t   w_req_size;
    logic        w_req_store;
    logic        w_req_load;
    logic        w_req_misaligned;
    logic [31:0] w_load_data;

    assign w_req_size       = op_size(req_op_i);
    assign w_req_store      = op_is_store(req_op_i);
    assign w_req_load       = op_is_load(req_op_i);
    assign w_req_misaligned = misaligned(w_req_size, req_addr_i[1:0]);

    // Combinational so the pipeline freezes in the very cycle a request is offered.
    assign stall_o = (r_state != MAU_IDLE) || (req_valid_i && (r_state == MAU_IDLE));

    mem_load_align u_load_align (
        .op_i      (r_op),
        .addr_lo_i (r_addr_lo),
        .word_i    (ram_data_i),
        .result_o  (w_load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= MAU_IDLE;
            r_op         <= 4'h0;
            r_addr_lo    <= 2'b00;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            exc_adel_o   <= 1'b0;
            exc_ades_o   <= 1'b0;
            ram_ce_o     <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_addr_o   <= '0;
            ram_sel_o    <= 4'b0000;
            ram_data_o   <= '0;
        end else begin
            case (r_state)
                MAU_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        r_op        <= req_op_i;
                        r_addr_lo   <= req_addr_i[1:0];
                        req_ready_o <= 1'b0;
                        if (w_req_size == SZ_NONE) begin
                            r_state      <= MAU_RESP;
                            resp_valid_o <= 1'b1;
                        end else if (w_req_misaligned) begin
                            r_state      <= MAU_RESP;
                            resp_valid_o <= 1'b1;
                            exc_adel_o   <= w_req_load;
                            exc_ades_o   <= w_req_store;
                        end else begin
                            // RAM pins are registered here so they are stable for the whole ACCESS cycle.
                            r_state    <= MAU_ACCESS;
                            ram_ce_o   <= 1'b1;
                            ram_we_o   <= w_req_store;
                            ram_addr_o <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            ram_sel_o  <= lane_mask(w_req_size, req_addr_i[1:0]);
                            ram_data_o <= w_req_store ? store_data(w_req_size, req_wdata_i) : '0;
                        end
                    end
                end
                MAU_ACCESS: begin
                    r_state      <= MAU_RESP;
                    ram_ce_o     <= 1'b0;
                    ram_we_o     <= 1'b0;
                    ram_addr_o   <= '0;
                    ram_sel_o    <= 4'b0000;
                    ram_data_o   <= '0;
                    resp_valid_o <= 1'b1;
                    resp_rdata_o <= w_load_data;
                end
                MAU_RESP: begin
                    r_state      <= MAU_IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_rdata_o <= '0;
                    exc_adel_o   <= 1'b0;
                    exc_ades_o   <= 1'b0;
                end
                default: begin
                    r_state     <= MAU_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Randomised and directed bench for mem_access_unit with a
//               byte-array reference model of the RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic        stall;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .exc_adel_o   (exc_adel),
        .exc_ades_o   (exc_ades),
        .stall_o      (stall),
        .ram_ce_o     (ram_ce),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_sel_o    (ram_sel),
        .ram_data_o   (ram_wdata),
        .ram_data_i   (ram_rdata)
    );

    // Environment RAM: combinational read, edge-committed lane writes.
    logic [31:0] ram [0:15];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = 4'h0;
    logic [31:0] poke_val = 32'h0;

    assign ram_rdata = ram[ram_addr[5:2]];

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        else if (ram_ce && ram_we) begin
            if (ram_sel[3]) ram[ram_addr[5:2]][31:24] <= ram_wdata[31:24];
            if (ram_sel[2]) ram[ram_addr[5:2]][23:16] <= ram_wdata[23:16];
            if (ram_sel[1]) ram[ram_addr[5:2]][15:8]  <= ram_wdata[15:8];
            if (ram_sel[0]) ram[ram_addr[5:2]][7:0]   <= ram_wdata[7:0];
        end
    end

    // Reference model: plain byte-addressed memory, lowest address = most significant.
    logic [7:0] ref_mem [0:63];

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
            MEM_OP_LW, MEM_OP_SW:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit is_st(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic bit is_mis(input logic [3:0] op, input int a);
        return (op_bytes(op) != 0) && ((a % op_bytes(op)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input int a);
        logic [31:0] v = 32'h0;
        int n = op_bytes(op);
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_mem[a + i]};
        if ((op == MEM_OP_LB) && v[7])  v = v | 32'hFFFF_FF00;
        if ((op == MEM_OP_LH) && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b = a - (a % 4);
        return {ref_mem[b], ref_mem[b + 1], ref_mem[b + 2], ref_mem[b + 3]};
    endfunction

    function automatic logic [3:0] exp_sel(input int n, input int a);
        logic [3:0] s = 4'b0000;
        for (int i = 0; i < n; i++) s[3 - ((a + i) % 4)] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_data(input int n, input logic [31:0] w);
        if (n == 1) return {4{w[7:0]}};
        if (n == 2) return {2{w[15:0]}};
        return w;
    endfunction

    task automatic ref_store(input logic [3:0] op, input int a, input logic [31:0] w);
        int n = op_bytes(op);
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(w >> (8 * (n - 1 - i)));
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx[3:0];
        poke_val = val;
        for (int i = 0; i < 4; i++) ref_mem[idx * 4 + i] = 8'(val >> (24 - 8 * i));
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Drives one request and records what the RAM pins and response looked like.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic adel,
                         output logic ades, output logic ce_seen, output logic we_seen,
                         output logic [3:0] sel_seen, output logic [31:0] data_seen,
                         output logic [31:0] addr_seen, output logic timeout);
        int n = 0;
        lat = 0; rdata = 32'h0; adel = 1'b0; ades = 1'b0; ce_seen = 1'b0; we_seen = 1'b0;
        sel_seen = 4'h0; data_seen = 32'h0; addr_seen = 32'h0; timeout = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ram_ce) begin
                ce_seen = 1'b1; we_seen = ram_we; sel_seen = ram_sel;
                data_seen = ram_wdata; addr_seen = ram_addr;
            end
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; adel = exc_adel; ades = exc_ades;
                break;
            end
        end
        if (lat == 0) timeout = 1'b1;
    endtask

    int          lat;
    logic [31:0] rdata, data_seen, addr_seen;
    logic        adel, ades, ce_seen, we_seen, timeout;
    logic [3:0]  sel_seen;

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_rdata, exc_adel, exc_ades, stall, ram_ce, ram_we, ram_addr,
             ram_sel, ram_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rv=%b rd=%h ce=%b we=%b addr=%h sel=%b data=%h stall=%b",
                     resp_valid, resp_rdata, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, stall);
        end
        rst = 1'b1;
    endtask

    task automatic test_store_word();
        issue(MEM_OP_SW, 32'h10, 32'h1122_3344, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        ref_store(MEM_OP_SW, 16, 32'h1122_3344);
        checks++;
        if (timeout || lat != 2) begin
            failures++;
            $display("FAIL sw_latency: got %0d want 2 (timeout=%b)", lat, timeout);
        end
        checks++;
        if ({ce_seen, we_seen, sel_seen, addr_seen, data_seen} !== {1'b1, 1'b1, 4'b1111, 32'h10, 32'h1122_3344}) begin
            failures++;
            $display("FAIL sw_pins: ce=%b we=%b sel=%b addr=%h data=%h want 1 1 1111 10 11223344",
                     ce_seen, we_seen, sel_seen, addr_seen, data_seen);
        end
        checks++;
        if (ram[4] !== ref_word(16)) begin
            failures++;
            $display("FAIL sw_ram: got %h want %h", ram[4], ref_word(16));
        end
    endtask

    task automatic test_byte_loads();
        poke(4, 32'h11F2_3344);
        issue(MEM_OP_LB, 32'h11, 32'h0, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || sel_seen !== 4'b0100 || we_seen !== 1'b0 || rdata !== 32'hFFFF_FFF2) begin
            failures++;
            $display("FAIL lb: sel=%b we=%b rdata=%h want 0100 0 fffffff2", sel_seen, we_seen, rdata);
        end
        issue(MEM_OP_LBU, 32'h11, 32'h0, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || rdata !== 32'h0000_00F2) begin
            failures++;
            $display("FAIL lbu: rdata=%h want 000000f2", rdata);
        end
    endtask

    task automatic test_half_store();
        issue(MEM_OP_SH, 32'h12, 32'h0000_ABCD, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        ref_store(MEM_OP_SH, 18, 32'h0000_ABCD);
        checks++;
        if (timeout || sel_seen !== 4'b0011 || data_seen !== 32'hABCD_ABCD || rdata !== 32'h0) begin
            failures++;
            $display("FAIL sh_pins: sel=%b data=%h rdata=%h want 0011 abcdabcd 0", sel_seen, data_seen, rdata);
        end
        issue(MEM_OP_LW, 32'h10, 32'h0, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || rdata !== 32'h11F2_ABCD) begin
            failures++;
            $display("FAIL sh_readback: rdata=%h want 11f2abcd", rdata);
        end
    endtask

    task automatic test_misaligned();
        issue(MEM_OP_LW, 32'h13, 32'h0, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || lat != 1 || adel !== 1'b1 || ades !== 1'b0 || rdata !== 32'h0 || ce_seen !== 1'b0) begin
            failures++;
            $display("FAIL adel: lat=%0d adel=%b ades=%b rdata=%h ce=%b want 1 1 0 0 0",
                     lat, adel, ades, rdata, ce_seen);
        end
        issue(MEM_OP_SH, 32'h15, 32'h1234, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || lat != 1 || adel !== 1'b0 || ades !== 1'b1 || rdata !== 32'h0 || ce_seen !== 1'b0) begin
            failures++;
            $display("FAIL ades: lat=%0d adel=%b ades=%b rdata=%h ce=%b want 1 0 1 0 0",
                     lat, adel, ades, rdata, ce_seen);
        end
    endtask

    task automatic test_nop();
        issue(4'hF, 32'h20, 32'hDEAD_BEEF, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || rdata !== 32'h0 || adel !== 1'b0 || ades !== 1'b0 || ce_seen !== 1'b0) begin
            failures++;
            $display("FAIL nop: timeout=%b rdata=%h adel=%b ades=%b ce=%b want 0 0 0 0 0",
                     timeout, rdata, adel, ades, ce_seen);
        end
    endtask

    task automatic test_back_to_back();
        int r1 = 0, r2 = 0, acc2 = 0;
        logic [31:0] d1 = 32'h0, d2 = 32'h0;
        logic stall_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_OP_LW; req_addr = 32'h10;
        @(posedge clk);
        #1 req_op = MEM_OP_LH; req_addr = 32'h12;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (acc2 == 0 && !stall) stall_ok = 1'b0;
            if (resp_valid) begin
                if (r1 == 0) begin r1 = k; d1 = resp_rdata; end
                else begin r2 = k; d2 = resp_rdata; end
            end
            if (acc2 == 0 && req_ready) begin
                acc2 = k;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (!stall_ok || acc2 != 3) begin
            failures++;
            $display("FAIL b2b_handshake: stall_ok=%b second_accept=%0d want 1 3", stall_ok, acc2);
        end
        checks++;
        if (r1 != 2 || r2 != 5) begin
            failures++;
            $display("FAIL b2b_timing: resp at %0d,%0d want 2,5", r1, r2);
        end
        checks++;
        if (d1 !== ref_load(MEM_OP_LW, 16) || d2 !== ref_load(MEM_OP_LH, 18)) begin
            failures++;
            $display("FAIL b2b_data: got %h,%h want %h,%h", d1, d2,
                     ref_load(MEM_OP_LW, 16), ref_load(MEM_OP_LH, 18));
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [9];
        ops = '{MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW,
                MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, 4'hF};
        for (int it = 0; it < 60; it++) begin
            logic [3:0]  op = ops[$urandom_range(0, 8)];
            int          a = int'($urandom_range(0, 63));
            logic [31:0] w = $urandom;
            int          n = op_bytes(op);
            bit          mis = is_mis(op, a);
            bit          st = is_st(op);
            bit          acc = (n != 0) && !mis;
            logic [31:0] exp_rd = (acc && !st) ? ref_load(op, a) : 32'h0;
            issue(op, 32'(a), w, lat, rdata, adel, ades, ce_seen, we_seen,
                  sel_seen, data_seen, addr_seen, timeout);
            checks++;
            if (timeout || (n != 0 && lat != (mis ? 1 : 2))) begin
                failures++;
                $display("FAIL rnd_latency: op=%h addr=%0d lat=%0d timeout=%b", op, a, lat, timeout);
            end
            checks++;
            if (rdata !== exp_rd || adel !== (mis && !st) || ades !== (mis && st)) begin
                failures++;
                $display("FAIL rnd_resp: op=%h addr=%0d rdata=%h adel=%b ades=%b want %h %b %b",
                         op, a, rdata, adel, ades, exp_rd, mis && !st, mis && st);
            end
            checks++;
            if (ce_seen !== acc || (acc && (we_seen !== st || sel_seen !== exp_sel(n, a) ||
                addr_seen !== 32'(a - a % 4) || (st && data_seen !== exp_data(n, w))))) begin
                failures++;
                $display("FAIL rnd_pins: op=%h addr=%0d ce=%b we=%b sel=%b addr=%h data=%h want ce=%b sel=%b",
                         op, a, ce_seen, we_seen, sel_seen, addr_seen, data_seen, acc, exp_sel(n, a));
            end
            if (acc && st) ref_store(op, a, w);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (ram[i] !== ref_word(i * 4)) begin
                failures++;
                $display("FAIL rnd_ram: word %0d got %h want %h", i, ram[i], ref_word(i * 4));
                break;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic ce_mid, drop_ok, no_resp = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_OP_SB; req_addr = 32'h21; req_wdata = 32'h0000_005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #3 ce_mid = ram_ce && ram_we;
        rst = 1'b0;
        #1 drop_ok = !ram_ce && !ram_we;
        checks++;
        if (!ce_mid || !drop_ok) begin
            failures++;
            $display("FAIL rst_mid_drop: active_before=%b dropped_after=%b want 1 1", ce_mid, drop_ok);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) no_resp = 1'b0;
        end
        checks++;
        if (!no_resp || ram[8] !== ref_word(32)) begin
            failures++;
            $display("FAIL rst_mid_effect: no_resp=%b ram=%h want 1 %h", no_resp, ram[8], ref_word(32));
        end
        issue(MEM_OP_LBU, 32'h21, 32'h0, lat, rdata, adel, ades, ce_seen, we_seen,
              sel_seen, data_seen, addr_seen, timeout);
        checks++;
        if (timeout || rdata !== ref_load(MEM_OP_LBU, 33)) begin
            failures++;
            $display("FAIL rst_mid_readback: rdata=%h want %h", rdata, ref_load(MEM_OP_LBU, 33));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        test_reset();
        test_store_word();
        test_byte_loads();
        test_half_store();
        test_misaligned();
        test_nop();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequencing front-end between the MEM pipeline stage and the byte-lane data RAM.
- Accepts one load/store request at a time over a valid/ready handshake and drives the RAM's ce/we/addr/sel/data pins for exactly one access cycle.
- Captures and aligns read data (byte/halfword extraction, sign/zero extension) and returns a registered response; raises stall while busy.
- Flags misaligned accesses as address-error exceptions without touching the RAM.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width (fixed 4 byte lanes)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  MEM stage presents a request
- req_ready_o  out  1  unit can accept a request this cycle
- req_op_i  in  4  access opcode (MEM_OP_* codes)
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  store data, right-justified
- resp_valid_o  out  1  one-cycle pulse: request complete
- resp_rdata_o  out  DATA_W  aligned/extended load data; 0 for stores and exceptions
- exc_adel_o  out  1  misaligned load (valid with resp_valid_o)
- exc_ades_o  out  1  misaligned store (valid with resp_valid_o)
- stall_o  out  1  high while a request is in flight
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address, word-aligned (low 2 bits 0)
- ram_sel_o  out  4  RAM byte-lane select
- ram_data_o  out  DATA_W  RAM write data, lane-replicated
- ram_data_i  in  DATA_W  RAM read data, combinational on addr

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 except req_ready_o=1; internal request registers cleared. Reset mid-access abandons the request, no response is produced, and ram_ce_o/ram_we_o drop immediately.
- Opcodes: LB, LBU, LH, LHU, LW, SB, SH, SW. Unknown opcode is treated as a NOP: completes with resp_valid_o, rdata 0, no exception, no RAM access.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready_o=1. A request is accepted when req_valid_i && req_ready_o. On acceptance, op/addr/wdata are latched.
  - Misaligned accesses (halfword with addr[0]=1; word with addr[1:0]!=0) go directly to RESP with the exception flag latched.
  - All other requests go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_ce_o=1; ram_addr_o = {addr[ADDR_W-1:2],2'b00}.
  - Stores: ram_we_o=1. Loads: ram_we_o=0.
  - Load data: ram_data_i is sampled at the end of this cycle, then extracted and extended before registering. Next state RESP.
- RESP (1 cycle): resp_valid_o=1 with registered rdata/exception flags. req_ready_o=0. Next state IDLE. Back-to-back requests are accepted in the following IDLE cycle.
- Outside ACCESS: ram_ce_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0, ram_data_o=0.
- stall_o = (state != IDLE) || (req_valid_i && state==IDLE). It is combinational, so the pipeline freezes in the acceptance cycle.
- Latency: acceptance cycle T; RAM access T+1; resp_valid_o at T+2. Misaligned accesses respond at T+1.
- Byte ordering is big-endian. addr[1:0] selects the lane as follows:
  - 00 -> sel 1000 (bits 31:24); 01 -> 0100; 10 -> 0010; 11 -> 0001.
  - Halfword: addr[1]=0 -> 1100; addr[1]=1 -> 0011.
  - Word -> 1111.
  - Loads also drive ram_sel_o with the lane mask.
- Store data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word passthrough.
- Load extraction: the selected lane is right-justified. LB/LH sign-extend from the MSB of the lane; LBU/LHU zero-extend.
- Exception cycle: resp_rdata_o=0. Exactly one of exc_adel_o/exc_ades_o is set.
- req_valid_i while not ready: ignored. The requester must hold the request until accepted.

Decomposition:
- Shared header defines.v gains:
  - MEM_OP_* 4-bit opcode constants.
  - State encodings MAU_IDLE/MAU_ACCESS/MAU_RESP.
  - Lane-mask constants.
- One sub-module, mem_load_align: a combinational extract/extend of {op, addr[1:0], word} -> 32-bit result. It is reused later by the cache path.

Test Plan:
- Reset: hold rst=0 -> req_ready_o=1, every other output 0. Release rst and issue SW 0x00000010, data 0x11223344 -> ACCESS cycle shows ce=1, we=1, sel=1111, addr=0x10, data=0x11223344; resp_valid_o at T+2.
- Signed byte load: RAM word at 0x10 = 0x11F23344, issue LB addr 0x11 -> sel=0100, resp_rdata_o=0xFFFFFFF2. LBU at the same address -> 0x000000F2.
- Halfword store: SH addr 0x12, wdata 0x0000ABCD -> sel=0011, ram_data_o=0xABCDABCD. A subsequent LW 0x10 returns 0x11F2ABCD, confirming only the low halfword changed.
- Misaligned accesses: LW addr 0x13 -> resp_valid_o at T+1 with exc_adel_o=1, rdata 0, ram_ce_o never asserted. SH addr 0x15 -> exc_ades_o=1.
- Back-to-back handshake: req_valid_i held high with LW 0x10 then LH 0x12 -> second request accepted only in the IDLE cycle after the first RESP, stall_o high continuously, responses 3 cycles apart.
- Reset mid-access: assert rst=0 during ACCESS of an SB -> ce/we drop asynchronously, no resp_valid_o after release, and the RAM byte is unchanged when the bench models the write as edge-committed.
